// File: rtl/frame_scanner.sv
// Replays a captured frame from the frame-buffer BRAM as the marker-framed
// (rdaddress, rddata) pixel stream consumed by detect_direction.
module frame_scanner #(
  parameter int IMAGE_WIDTH  = 320,
  parameter int IMAGE_HEIGHT = 240,
  parameter int ADDR_BITS    = $clog2(IMAGE_WIDTH * IMAGE_HEIGHT),
  parameter int PIXEL_BITS   = 12,
  parameter int BRAM_LATENCY = 1,
  parameter int MIN_HOLD     = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  frame_ready,
  output logic [ADDR_BITS-1:0]  bram_rdaddress,
  input  logic [PIXEL_BITS-1:0] bram_q,
  output logic [ADDR_BITS-1:0]  rdaddress,
  output logic [PIXEL_BITS-1:0] rddata,
  output logic                  scan_busy,
  output logic                  frame_done,
  output logic                  frame_dropped,
  output logic [15:0]           frame_count
);

  localparam int NUM_PIX = IMAGE_WIDTH * IMAGE_HEIGHT;
  localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(NUM_PIX - 1);
  localparam logic [ADDR_BITS-1:0] ADDR_ONE  = ADDR_BITS'(1);
  localparam logic [ADDR_BITS-1:0] ADDR_TWO  = ADDR_BITS'(2);
  localparam int HOLD_BITS = $clog2(MIN_HOLD + 1);
  localparam logic [HOLD_BITS-1:0] HOLD_MIN = HOLD_BITS'(MIN_HOLD);
  localparam logic [HOLD_BITS-1:0] HOLD_ONE = HOLD_BITS'(1);

  typedef enum logic [2:0] {IDLE, START, SCAN, DRAIN, HOLD} state_t;

  state_t state, state_nxt;

  logic [ADDR_BITS-1:0]    dl_addr [BRAM_LATENCY];
  logic [BRAM_LATENCY-1:0] dl_valid;
  logic                    pending;
  logic [HOLD_BITS-1:0]    hold_cnt;

  logic [ADDR_BITS-1:0]  bram_addr_nxt;
  logic                  issue_nxt;
  logic [ADDR_BITS-1:0]  rdaddress_nxt;
  logic [PIXEL_BITS-1:0] rddata_nxt;
  logic                  busy_nxt;
  logic                  done_nxt;
  logic                  drop_nxt;
  logic [15:0]           count_nxt;
  logic                  pending_nxt;
  logic [HOLD_BITS-1:0]  hold_nxt;
  logic                  start_scan;
  logic                  pix_valid;
  logic [ADDR_BITS-1:0]  pix_addr;

  // The last delay-line stage lines up with bram_q for the same address
  assign pix_valid = dl_valid[BRAM_LATENCY-1];
  assign pix_addr  = dl_addr[BRAM_LATENCY-1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    bram_addr_nxt = bram_rdaddress;
    issue_nxt     = 1'b0;
    rdaddress_nxt = rdaddress;
    rddata_nxt    = rddata;
    busy_nxt      = scan_busy;
    done_nxt      = 1'b0;
    drop_nxt      = 1'b0;
    count_nxt     = frame_count;
    pending_nxt   = pending;
    hold_nxt      = hold_cnt;
    start_scan    = 1'b0;

    case (state)
      IDLE: begin
        rdaddress_nxt = '0;
        rddata_nxt    = '0;
        if (hold_cnt < HOLD_MIN) hold_nxt = hold_cnt + HOLD_ONE;
        if ((frame_ready || pending) && (hold_cnt >= HOLD_MIN)) begin
          start_scan    = 1'b1;
          state_nxt     = START;
          rdaddress_nxt = ADDR_ONE;
          busy_nxt      = 1'b1;
          bram_addr_nxt = ADDR_TWO;
          issue_nxt     = 1'b1;
        end
      end
      START, SCAN: begin
        if (pix_valid) begin
          rdaddress_nxt = pix_addr;
          rddata_nxt    = bram_q;
          state_nxt     = SCAN;
        end
        if (bram_rdaddress < LAST_ADDR) begin
          bram_addr_nxt = bram_rdaddress + ADDR_ONE;
          issue_nxt     = 1'b1;
        end else begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (pix_valid) begin
          rdaddress_nxt = pix_addr;
          rddata_nxt    = bram_q;
        end else begin
          state_nxt     = HOLD;
          rdaddress_nxt = '0;
          rddata_nxt    = '0;
          busy_nxt      = 1'b0;
          done_nxt      = 1'b1;
          count_nxt     = frame_count + 16'd1;
          hold_nxt      = HOLD_ONE;
        end
      end
      HOLD: begin
        state_nxt = IDLE;
        if (hold_cnt < HOLD_MIN) hold_nxt = hold_cnt + HOLD_ONE;
      end
      default: state_nxt = IDLE;
    endcase

    // One request may wait while a scan runs; any further one is discarded
    if (start_scan) begin
      pending_nxt = 1'b0;
    end else if (frame_ready) begin
      pending_nxt = 1'b1;
      drop_nxt    = pending;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bram_rdaddress <= '0;
      rdaddress      <= '0;
      rddata         <= '0;
      scan_busy      <= 1'b0;
      frame_done     <= 1'b0;
      frame_dropped  <= 1'b0;
      frame_count    <= '0;
      pending        <= 1'b0;
      hold_cnt       <= '0;
      dl_valid       <= '0;
      for (int k = 0; k < BRAM_LATENCY; k++) dl_addr[k] <= '0;
    end else begin
      bram_rdaddress <= bram_addr_nxt;
      rdaddress      <= rdaddress_nxt;
      rddata         <= rddata_nxt;
      scan_busy      <= busy_nxt;
      frame_done     <= done_nxt;
      frame_dropped  <= drop_nxt;
      frame_count    <= count_nxt;
      pending        <= pending_nxt;
      hold_cnt       <= hold_nxt;
      dl_addr[0]     <= bram_addr_nxt;
      dl_valid[0]    <= issue_nxt;
      for (int k = 1; k < BRAM_LATENCY; k++) begin
        dl_addr[k]  <= dl_addr[k-1];
        dl_valid[k] <= dl_valid[k-1];
      end
    end
  end

endmodule

// File: tb/tb_frame_scanner.sv
// Bench for frame_scanner: an 8x4 frame at BRAM latency 1 and 3, checked by a
// scan-schedule model every cycle plus hand-computed trace expectations.
module tb_frame_scanner;

  localparam int W  = 8;
  localparam int H  = 4;
  localparam int NP = W * H;
  localparam int AB = 5;
  localparam int PB = 12;
  localparam int MH = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic fr1 = 1'b0;
  logic fr3 = 1'b0;

  logic [AB-1:0] ba1, rda1, ba3, rda3;
  logic [PB-1:0] q1, rdd1, q3, rdd3, q3a, q3b;
  logic busy1, done1, drop1, busy3, done3, drop3;
  logic [15:0] cnt1, cnt3;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  frame_scanner #(.IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .ADDR_BITS(AB), .PIXEL_BITS(PB),
                  .BRAM_LATENCY(1), .MIN_HOLD(MH)) dut1 (
    .clk(clk), .reset_n(reset_n), .frame_ready(fr1), .bram_rdaddress(ba1), .bram_q(q1),
    .rdaddress(rda1), .rddata(rdd1), .scan_busy(busy1), .frame_done(done1),
    .frame_dropped(drop1), .frame_count(cnt1));

  frame_scanner #(.IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .ADDR_BITS(AB), .PIXEL_BITS(PB),
                  .BRAM_LATENCY(3), .MIN_HOLD(MH)) dut3 (
    .clk(clk), .reset_n(reset_n), .frame_ready(fr3), .bram_rdaddress(ba3), .bram_q(q3),
    .rdaddress(rda3), .rddata(rdd3), .scan_busy(busy3), .frame_done(done3),
    .frame_dropped(drop3), .frame_count(cnt3));

  // BRAM holding mem[a] = a, with latency-1 extra register stages
  assign q1 = PB'(ba1);
  always @(posedge clk) begin
    q3a <= PB'(ba3);
    q3b <= q3a;
  end
  assign q3 = q3b;

  task automatic checkOutput(input string name, input int actual, input int expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Model: a scan started on edge s shows marker for L edges, then pixel
  // t-L+2 on edge s+t, and completes on edge s+L+NP-2.
  int  lat [2] = '{1, 3};
  bit  m_scan [2] = '{0, 0};
  bit  m_pend [2] = '{0, 0};
  int  m_start [2] = '{0, 0};
  int  m_ready [2] = '{0, 0};
  int  m_count [2] = '{0, 0};
  int  e_rda [2], e_rdd [2];
  bit  e_busy [2], e_done [2], e_drop [2];
  int  edge_n = 0;

  always @(posedge clk) begin
    bit fr;
    bit was;
    bit start;
    int t;
    edge_n++;
    for (int i = 0; i < 2; i++) begin
      fr = (i == 0) ? fr1 : fr3;
      e_done[i] = 1'b0;
      e_drop[i] = 1'b0;
      if (!reset_n) begin
        m_scan[i]  = 1'b0;
        m_pend[i]  = 1'b0;
        m_count[i] = 0;
        m_ready[i] = edge_n + 1 + MH;
      end else begin
        was = m_scan[i];
        if (was && edge_n == m_start[i] + lat[i] + NP - 2) begin
          m_scan[i]  = 1'b0;
          m_count[i] = (m_count[i] + 1) % 65536;
          m_ready[i] = edge_n + MH;
          e_done[i]  = 1'b1;
        end
        start = !was && (edge_n >= m_ready[i]) && (fr || m_pend[i]);
        if (start) begin
          m_scan[i]  = 1'b1;
          m_start[i] = edge_n;
          m_pend[i]  = 1'b0;
        end else if (fr) begin
          e_drop[i] = m_pend[i];
          m_pend[i] = 1'b1;
        end
      end
      e_busy[i] = m_scan[i];
      if (m_scan[i]) begin
        t = edge_n - m_start[i];
        e_rda[i] = (t < lat[i]) ? 1 : t - lat[i] + 2;
        e_rdd[i] = (t < lat[i]) ? 0 : t - lat[i] + 2;
      end else begin
        e_rda[i] = 0;
        e_rdd[i] = 0;
      end
    end
    #1;
    checkOutput("m1_rdaddress", int'(rda1), e_rda[0]);
    checkOutput("m1_rddata", int'(rdd1), e_rdd[0]);
    checkOutput("m1_busy", int'(busy1), int'(e_busy[0]));
    checkOutput("m1_done", int'(done1), int'(e_done[0]));
    checkOutput("m1_dropped", int'(drop1), int'(e_drop[0]));
    checkOutput("m1_count", int'(cnt1), m_count[0]);
    checkOutput("m1_bram_range", int'(ba1 <= AB'(NP - 1)), 1);
    checkOutput("m3_rdaddress", int'(rda3), e_rda[1]);
    checkOutput("m3_rddata", int'(rdd3), e_rdd[1]);
    checkOutput("m3_busy", int'(busy3), int'(e_busy[1]));
    checkOutput("m3_done", int'(done3), int'(e_done[1]));
    checkOutput("m3_dropped", int'(drop3), int'(e_drop[1]));
    checkOutput("m3_count", int'(cnt3), m_count[1]);
    checkOutput("m3_bram_range", int'(ba3 <= AB'(NP - 1)), 1);
  end

  // Per-cycle trace of the selected instance, indexed by relative cycle
  int tr_rda [100], tr_rdd [100], tr_cnt [100];
  bit tr_busy [100], tr_done [100], tr_drop [100];

  task automatic applyStimulus(input int sel, input int fa, input int fb, input int fc,
                               input int ncyc);
    bit f;
    for (int k = 0; k < ncyc; k++) begin
      @(negedge clk);
      tr_rda[k]  = (sel == 0) ? int'(rda1) : int'(rda3);
      tr_rdd[k]  = (sel == 0) ? int'(rdd1) : int'(rdd3);
      tr_cnt[k]  = (sel == 0) ? int'(cnt1) : int'(cnt3);
      tr_busy[k] = (sel == 0) ? busy1 : busy3;
      tr_done[k] = (sel == 0) ? done1 : done3;
      tr_drop[k] = (sel == 0) ? drop1 : drop3;
      f = (k == fa) || (k == fb) || (k == fc);
      if (sel == 0) fr1 = f;
      else          fr3 = f;
    end
    @(negedge clk);
    fr1 = 1'b0;
    fr3 = 1'b0;
  endtask

  initial begin
    int n_done, n_drop, n_pix, n_mark, n_align, n_nz;

    // Reset state and idling
    repeat (3) @(negedge clk);
    checkOutput("rst_rdaddress", int'(rda1), 0);
    checkOutput("rst_rddata", int'(rdd1), 0);
    checkOutput("rst_busy", int'(busy1), 0);
    checkOutput("rst_done", int'(done1), 0);
    checkOutput("rst_count", int'(cnt1), 0);
    reset_n = 1'b1;
    applyStimulus(0, -1, -1, -1, 8);
    n_nz = 0;
    for (int k = 0; k < 8; k++) if (tr_rda[k] != 0 || tr_busy[k]) n_nz++;
    checkOutput("idle_quiet", n_nz, 0);

    // Single scan at latency 1
    applyStimulus(0, 0, -1, -1, 40);
    checkOutput("t2_marker_c1", tr_rda[1], 1);
    checkOutput("t2_marker_data", tr_rdd[1], 0);
    checkOutput("t2_first_addr", tr_rda[2], 2);
    checkOutput("t2_first_data", tr_rdd[2], 2);
    checkOutput("t2_last_addr", tr_rda[31], 31);
    checkOutput("t2_last_data", tr_rdd[31], 31);
    checkOutput("t2_busy_c31", int'(tr_busy[31]), 1);
    checkOutput("t2_done_c31", int'(tr_done[31]), 0);
    checkOutput("t2_zero_c32", tr_rda[32], 0);
    checkOutput("t2_done_c32", int'(tr_done[32]), 1);
    checkOutput("t2_busy_c32", int'(tr_busy[32]), 0);
    checkOutput("t2_count_c32", tr_cnt[32], 1);
    n_done = 0;
    for (int k = 0; k < 40; k++) n_done += int'(tr_done[k]);
    checkOutput("t2_done_pulses", n_done, 1);

    // Pending request honoured after the hold time
    applyStimulus(0, 0, 10, -1, 70);
    checkOutput("t3_hold_c33", tr_rda[33], 0);
    checkOutput("t3_marker_c34", tr_rda[34], 1);
    checkOutput("t3_pixel_c35", tr_rda[35], 2);
    checkOutput("t3_done_c65", int'(tr_done[65]), 1);
    n_done = 0;
    n_drop = 0;
    for (int k = 0; k < 70; k++) begin
      n_done += int'(tr_done[k]);
      n_drop += int'(tr_drop[k]);
    end
    checkOutput("t3_done_pulses", n_done, 2);
    checkOutput("t3_drops", n_drop, 0);
    checkOutput("t3_count", tr_cnt[69], 3);

    // Third request while one is pending is dropped
    applyStimulus(0, 0, 10, 20, 70);
    checkOutput("t4_drop_c21", int'(tr_drop[21]), 1);
    n_done = 0;
    n_drop = 0;
    for (int k = 0; k < 70; k++) begin
      n_done += int'(tr_done[k]);
      n_drop += int'(tr_drop[k]);
    end
    checkOutput("t4_done_pulses", n_done, 2);
    checkOutput("t4_drops", n_drop, 1);
    checkOutput("t4_count", tr_cnt[69], 5);

    // Reset in the middle of a scan
    applyStimulus(0, 0, -1, -1, 15);
    checkOutput("t5_pre_addr", int'(rda1), 15);
    checkOutput("t5_pre_busy", int'(busy1), 1);
    reset_n = 1'b0;
    #1;
    checkOutput("t5_async_addr", int'(rda1), 0);
    checkOutput("t5_async_data", int'(rdd1), 0);
    checkOutput("t5_async_busy", int'(busy1), 0);
    checkOutput("t5_async_count", int'(cnt1), 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    applyStimulus(0, -1, -1, -1, 5);
    n_done = 0;
    for (int k = 0; k < 5; k++) n_done += int'(tr_done[k]);
    checkOutput("t5_no_done", n_done, 0);
    applyStimulus(0, 0, -1, -1, 40);
    n_pix = 0;
    for (int k = 0; k < 40; k++) if (tr_rda[k] >= 2) n_pix++;
    checkOutput("t5_marker_c1", tr_rda[1], 1);
    checkOutput("t5_pixels", n_pix, 30);
    checkOutput("t5_done_c32", int'(tr_done[32]), 1);
    checkOutput("t5_count", tr_cnt[32], 1);

    // Latency 3 instance
    applyStimulus(1, 0, -1, -1, 40);
    n_mark = 0;
    n_pix = 0;
    n_align = 0;
    for (int k = 0; k < 40; k++) begin
      if (tr_rda[k] == 1) n_mark++;
      if (tr_rda[k] >= 2) begin
        n_pix++;
        if (tr_rdd[k] == tr_rda[k]) n_align++;
      end
    end
    checkOutput("t6_marker_c3", tr_rda[3], 1);
    checkOutput("t6_first_addr", tr_rda[4], 2);
    checkOutput("t6_first_data", tr_rdd[4], 2);
    checkOutput("t6_markers", n_mark, 3);
    checkOutput("t6_pixels", n_pix, 30);
    checkOutput("t6_aligned", n_align, 30);
    checkOutput("t6_done_c34", int'(tr_done[34]), 1);
    checkOutput("t6_count", tr_cnt[39], 1);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
